uart_bus_arbiter: RTL and testbench

UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/uart_bus_arbiter.sv | 119 +++++++++++
 tb/tb_uart_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the two-master UART register-port arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int          DEF_TIMEOUT_CYCLES = 256;
  localparam logic [31:0] DEF_ERR_RDATA      = 32'hDEAD_0BAD;

endpackage

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter letting the CPU data port (m0) and a second requester (m1)
// share the UART register port, with a slave-response timeout.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_daddr_i,
  input  logic [31:0] m0_dwdata_i,
  input  logic [3:0]  m0_dstrb_i,
  input  logic        m0_dwrite_i,
  input  logic        m0_dvalid_i,
  output logic [31:0] m0_drdata_o,
  output logic        m0_dready_o,
  input  logic [31:0] m1_daddr_i,
  input  logic [31:0] m1_dwdata_i,
  input  logic [3:0]  m1_dstrb_i,
  input  logic        m1_dwrite_i,
  input  logic        m1_dvalid_i,
  output logic [31:0] m1_drdata_o,
  output logic        m1_dready_o,
  output logic [31:0] s_daddr_o,
  output logic [31:0] s_dwdata_o,
  output logic [3:0]  s_dstrb_o,
  output logic        s_dwrite_o,
  output logic        s_dvalid_o,
  input  logic [31:0] s_drdata_i,
  input  logic        s_dready_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;

  logic        sel_m1;
  logic        own_valid;
  logic        timeout_hit;
  logic        done_rdy;
  logic [31:0] done_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= 16'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wait_cnt   <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = 16'd0;
    sel_m1         = (state == OWN1);
    own_valid      = 1'b0;
    timeout_hit    = 1'b0;
    done_rdy       = 1'b0;
    done_rdata     = 32'd0;
    s_daddr_o      = 32'd0;
    s_dwdata_o     = 32'd0;
    s_dstrb_o      = 4'd0;
    s_dwrite_o     = 1'b0;
    s_dvalid_o     = 1'b0;
    m0_dready_o    = 1'b0;
    m0_drdata_o    = 32'd0;
    m1_dready_o    = 1'b0;
    m1_drdata_o    = 32'd0;
    grant_o        = 2'b00;
    timeout_o      = 1'b0;

    case (state)
      IDLE: begin
        // On contention the master that did not finish last goes next.
        if (m0_dvalid_i && m1_dvalid_i) state_nxt = last_grant ? OWN0 : OWN1;
        else if (m0_dvalid_i)           state_nxt = OWN0;
        else if (m1_dvalid_i)           state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        grant_o     = sel_m1 ? 2'b10 : 2'b01;
        own_valid   = sel_m1 ? m1_dvalid_i : m0_dvalid_i;
        timeout_hit = own_valid && !s_dready_i && (wait_cnt == WAIT_LAST);
        s_daddr_o   = sel_m1 ? m1_daddr_i  : m0_daddr_i;
        s_dwdata_o  = sel_m1 ? m1_dwdata_i : m0_dwdata_i;
        s_dstrb_o   = sel_m1 ? m1_dstrb_i  : m0_dstrb_i;
        s_dwrite_o  = sel_m1 ? m1_dwrite_i : m0_dwrite_i;
        // Withdraw the request in the timeout cycle so the slave cannot act on it.
        s_dvalid_o  = own_valid && !timeout_hit;
        done_rdy    = (own_valid && s_dready_i) || timeout_hit;
        done_rdata  = timeout_hit ? ERR_RDATA : s_drdata_i;
        timeout_o   = timeout_hit;
        if (sel_m1) begin
          m1_dready_o = done_rdy;
          m1_drdata_o = done_rdata;
        end else begin
          m0_dready_o = done_rdy;
          m0_drdata_o = done_rdata;
        end
        if (!own_valid || s_dready_i || timeout_hit) begin
          state_nxt      = IDLE;
          last_grant_nxt = sel_m1;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: an owner/age reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_uart_bus_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_0BAD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_daddr_i, m0_dwdata_i, m1_daddr_i, m1_dwdata_i;
  logic [3:0]  m0_dstrb_i, m1_dstrb_i;
  logic        m0_dwrite_i, m0_dvalid_i, m1_dwrite_i, m1_dvalid_i;
  logic [31:0] m0_drdata_o, m1_drdata_o;
  logic        m0_dready_o, m1_dready_o;
  logic [31:0] s_daddr_o, s_dwdata_o, s_drdata_i;
  logic [3:0]  s_dstrb_o;
  logic        s_dwrite_o, s_dvalid_o, s_dready_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  uart_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .m0_daddr_i(m0_daddr_i), .m0_dwdata_i(m0_dwdata_i), .m0_dstrb_i(m0_dstrb_i),
    .m0_dwrite_i(m0_dwrite_i), .m0_dvalid_i(m0_dvalid_i),
    .m0_drdata_o(m0_drdata_o), .m0_dready_o(m0_dready_o),
    .m1_daddr_i(m1_daddr_i), .m1_dwdata_i(m1_dwdata_i), .m1_dstrb_i(m1_dstrb_i),
    .m1_dwrite_i(m1_dwrite_i), .m1_dvalid_i(m1_dvalid_i),
    .m1_drdata_o(m1_drdata_o), .m1_dready_o(m1_dready_o),
    .s_daddr_o(s_daddr_o), .s_dwdata_o(s_dwdata_o), .s_dstrb_o(s_dstrb_o),
    .s_dwrite_o(s_dwrite_o), .s_dvalid_o(s_dvalid_o),
    .s_drdata_i(s_drdata_i), .s_dready_i(s_dready_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how long it has waited, who finished last.
  int owner = -1;
  int age   = 0;
  int last  = 1;
  bit live  = 1'b0;

  function automatic logic req(input int m);
    return (m == 1) ? m1_dvalid_i : m0_dvalid_i;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      owner = -1; age = 0; last = 1; live = 1'b1;
    end else if (live) begin
      if (owner < 0) begin
        if (m0_dvalid_i && m1_dvalid_i) owner = (last == 0) ? 1 : 0;
        else if (m0_dvalid_i)           owner = 0;
        else if (m1_dvalid_i)           owner = 1;
        age = 0;
      end else if (!req(owner) || s_dready_i || age == TO - 1) begin
        last  = owner;
        owner = -1;
      end else begin
        age++;
      end
    end
  end

  int rdy0 = 0, rdy1 = 0, to_cnt = 0, own_cyc = 0;
  int served[$];

  always @(negedge clk) begin
    if (live) begin
      logic        dv, tmo, r0, r1;
      logic [31:0] d0, d1, a, w;
      logic [3:0]  st;
      logic        wr;
      dv  = (owner >= 0) && req(owner);
      tmo = dv && !s_dready_i && (age == TO - 1);
      a   = (owner < 0) ? 32'd0 : (owner == 1) ? m1_daddr_i  : m0_daddr_i;
      w   = (owner < 0) ? 32'd0 : (owner == 1) ? m1_dwdata_i : m0_dwdata_i;
      st  = (owner < 0) ? 4'd0  : (owner == 1) ? m1_dstrb_i  : m0_dstrb_i;
      wr  = (owner < 0) ? 1'b0  : (owner == 1) ? m1_dwrite_i : m0_dwrite_i;
      r0  = (owner == 0) && ((dv && s_dready_i) || tmo);
      r1  = (owner == 1) && ((dv && s_dready_i) || tmo);
      d0  = (owner == 0) ? (tmo ? ERR : s_drdata_i) : 32'd0;
      d1  = (owner == 1) ? (tmo ? ERR : s_drdata_i) : 32'd0;
      chk("grant",    32'(grant_o), (owner < 0) ? 32'd0 : (owner == 1) ? 32'd2 : 32'd1);
      chk("timeout",  32'(timeout_o),  32'(tmo));
      chk("s_dvalid", 32'(s_dvalid_o), 32'(dv && !tmo));
      chk("s_daddr",  s_daddr_o,  a);
      chk("s_dwdata", s_dwdata_o, w);
      chk("s_dstrb",  32'(s_dstrb_o),  32'(st));
      chk("s_dwrite", 32'(s_dwrite_o), 32'(wr));
      chk("m0_dready", 32'(m0_dready_o), 32'(r0));
      chk("m0_drdata", m0_drdata_o, d0);
      chk("m1_dready", 32'(m1_dready_o), 32'(r1));
      chk("m1_drdata", m1_drdata_o, d1);
      if (s_dvalid_o && grant_o == 2'b00) chk("dvalid_without_grant", 32'd1, 32'd0);
      if (m0_dready_o) begin rdy0++; served.push_back(0); end
      if (m1_dready_o) begin rdy1++; served.push_back(1); end
      if (timeout_o) to_cnt++;
      if (grant_o != 2'b00) own_cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic quiet();
    m0_dvalid_i = 1'b0; m1_dvalid_i = 1'b0;
    s_dready_i  = 1'b0; s_drdata_i  = 32'd0;
  endtask

  initial begin
    int b0, b1, bt, bo;
    int exp_ord[4];
    exp_ord = '{0, 1, 0, 1};
    rst = 1'b1;
    m0_daddr_i = 0; m0_dwdata_i = 0; m0_dstrb_i = 0; m0_dwrite_i = 0;
    m1_daddr_i = 0; m1_dwdata_i = 0; m1_dstrb_i = 0; m1_dwrite_i = 0;
    quiet();
    step();
    reset_dut();
    @(negedge clk);
    chk("rst_grant",    32'(grant_o), 32'd0);
    chk("rst_s_dvalid", 32'(s_dvalid_o), 32'd0);
    chk("rst_m0_dready", 32'(m0_dready_o), 32'd0);

    // Scenario 1: m0 write, slave ready in third owned cycle
    step();
    b0 = rdy0;
    m0_daddr_i = 32'h0; m0_dwdata_i = 32'h41; m0_dstrb_i = 4'h1; m0_dwrite_i = 1'b1;
    m0_dvalid_i = 1'b1;
    @(negedge clk);
    chk("s1_t_dvalid", 32'(s_dvalid_o), 32'd0);
    step();
    @(negedge clk);
    chk("s1_t1_dvalid", 32'(s_dvalid_o), 32'd1);
    chk("s1_t1_grant",  32'(grant_o), 32'd1);
    chk("s1_t1_wdata",  s_dwdata_o, 32'h41);
    step();
    step();
    s_dready_i = 1'b1;
    @(negedge clk);
    chk("s1_dready", 32'(m0_dready_o), 32'd1);
    step();
    quiet();
    @(negedge clk);
    chk("s1_after_grant", 32'(grant_o), 32'd0);
    step();
    chk("s1_dready_pulses", 32'(rdy0 - b0), 32'd1);

    // Scenario 2: simultaneous requests after reset alternate m0, m1, m0, m1
    reset_dut();
    served.delete();
    m0_daddr_i = 32'h10; m0_dwrite_i = 1'b0;
    m1_daddr_i = 32'h20; m1_dwrite_i = 1'b0;
    m0_dvalid_i = 1'b1; m1_dvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      s_dready_i = 1'b1; s_drdata_i = 32'(i + 1);
      @(negedge clk);
      chk("s2_grant", 32'(grant_o), (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      s_dready_i = 1'b0;
      if (i == 3) quiet();
    end
    chk("s2_served_count", 32'(served.size()), 32'd4);
    for (int i = 0; i < 4 && i < served.size(); i++)
      chk("s2_order", 32'(served[i]), 32'(exp_ord[i]));

    // Scenario 3: m1 read returns 0xA5, m0 sees nothing
    m1_daddr_i = 32'h8; m1_dwrite_i = 1'b0; m1_dvalid_i = 1'b1;
    step();
    step();
    s_dready_i = 1'b1; s_drdata_i = 32'h0000_00A5;
    @(negedge clk);
    chk("s3_m1_drdata", m1_drdata_o, 32'h0000_00A5);
    chk("s3_m1_dready", 32'(m1_dready_o), 32'd1);
    chk("s3_m0_drdata", m0_drdata_o, 32'd0);
    step();
    quiet();

    // Scenario 4: slave never answers, timeout after TO owned cycles
    bo = own_cyc; bt = to_cnt;
    m0_daddr_i = 32'hC; m0_dwrite_i = 1'b0; m0_dvalid_i = 1'b1;
    for (int k = 0; k < TO; k++) step();
    @(negedge clk);
    chk("s4_dready",  32'(m0_dready_o), 32'd1);
    chk("s4_drdata",  m0_drdata_o, 32'hDEAD_0BAD);
    chk("s4_timeout", 32'(timeout_o), 32'd1);
    chk("s4_s_dvalid", 32'(s_dvalid_o), 32'd0);
    step();
    quiet();
    @(negedge clk);
    chk("s4_after_grant", 32'(grant_o), 32'd0);
    step();
    chk("s4_own_cycles", 32'(own_cyc - bo), 32'd4);
    chk("s4_timeouts",   32'(to_cnt - bt), 32'd1);

    // Scenario 5: slave ready in the timeout cycle wins
    m0_dvalid_i = 1'b1;
    for (int k = 0; k < TO; k++) step();
    s_dready_i = 1'b1; s_drdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("s5_drdata",  m0_drdata_o, 32'h1234_5678);
    chk("s5_timeout", 32'(timeout_o), 32'd0);
    chk("s5_dready",  32'(m0_dready_o), 32'd1);
    step();
    quiet();

    // Scenario 6: reset during an m1 transfer, then contention goes to m0
    b1 = rdy1; bt = to_cnt;
    m1_dvalid_i = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    quiet();
    @(negedge clk);
    chk("s6_grant_after_rst", 32'(grant_o), 32'd0);
    m0_dvalid_i = 1'b1; m1_dvalid_i = 1'b1;
    step();
    chk("s6_no_dready",  32'(rdy1 - b1), 32'd0);
    chk("s6_no_timeout", 32'(to_cnt - bt), 32'd0);
    @(negedge clk);
    chk("s6_grant_m0", 32'(grant_o), 32'd1);
    // m0 withdraws mid-transfer: abandoned without dready
    step();
    quiet();
    @(negedge clk);
    chk("s6_abandon_dready", 32'(m0_dready_o), 32'd0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
